rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_queue_pkg.sv | 35 +++
 rtl/rob_queue_sva.sv | 40 ++++
 rtl/rob_queue.sv | 100 ++++++++++
 tb/tb_rob_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_queue_pkg.sv
// rob_queue_pkg: shared sizing and type definitions for the reorder buffer
// queue and the retire stage that consumes its packets.
//   N               superscalar width (dispatch/retire slots per cycle)
//   ROB_SZ          number of ROB entries (>= N, need not be a power of two)
//   NUM_SCALAR_BITS width of a 0..N slot count
//   ROB_IDX         index into the ROB circular buffer
//   ROB_PACKET      per-instruction record (T_new, T_old, has_dest)
`ifndef N
`define N 3
`endif
`ifndef ROB_SZ
`define ROB_SZ 8
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N+1)
`endif

package rob_queue_pkg;

  localparam int N               = `N;
  localparam int ROB_SZ          = `ROB_SZ;
  localparam int NUM_SCALAR_BITS = `NUM_SCALAR_BITS;
  localparam int IDX_BITS        = (ROB_SZ > 1) ? $clog2(ROB_SZ) : 1;
  localparam int CNT_BITS        = $clog2(ROB_SZ + 1);
  localparam int PREG_BITS       = 6;

  typedef logic [IDX_BITS-1:0] ROB_IDX;

  typedef struct packed {
    logic [PREG_BITS-1:0] T_new;
    logic [PREG_BITS-1:0] T_old;
    logic                 has_dest;
  } ROB_PACKET;

endpackage

// File: rtl/rob_queue_sva.sv
// rob_queue_sva: interface-legality and occupancy checks bound into rob_queue.
// Ports:
//   clock, reset        same as rob_queue
//   rob_inputs_valid    dispatch count (must not exceed rob_spots)
//   rob_spots           advertised free slots
//   num_retiring        retire count (must not exceed rob_outputs_valid)
//   rob_outputs_valid   advertised visible entries
//   count               internal occupancy (must not exceed ROB_SZ)
module rob_queue_sva
  import rob_queue_pkg::*;
(
  input logic                       clock,
  input logic                       reset,
  input logic [NUM_SCALAR_BITS-1:0] rob_inputs_valid,
  input logic [NUM_SCALAR_BITS-1:0] rob_spots,
  input logic [NUM_SCALAR_BITS-1:0] num_retiring,
  input logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input logic [CNT_BITS-1:0]        count
);

  a_dispatch_fits: assert property (@(posedge clock) disable iff (!reset)
    rob_inputs_valid <= rob_spots);

  a_retire_visible: assert property (@(posedge clock) disable iff (!reset)
    num_retiring <= rob_outputs_valid);

  a_count_bounded: assert property (@(posedge clock) disable iff (!reset)
    count <= CNT_BITS'(ROB_SZ));

endmodule

bind rob_queue rob_queue_sva u_rob_queue_sva (
  .clock             (clock),
  .reset             (reset),
  .rob_inputs_valid  (rob_inputs_valid),
  .rob_spots         (rob_spots),
  .num_retiring      (num_retiring),
  .rob_outputs_valid (rob_outputs_valid),
  .count             (count)
);

// File: rtl/rob_queue.sv
// rob_queue: circular reorder buffer with N-wide dispatch and retire plus
// mispredict restore.
// Ports:
//   clock              sole clock, state updates on posedge
//   reset              asynchronous, active-low
//   rob_inputs         packets to dispatch, slot 0 oldest
//   rob_inputs_valid   number of valid dispatch slots (lowest indices)
//   rob_spots          min(free entries, N)
//   rob_tail           index that rob_inputs[0] lands in this cycle
//   rob_outputs        entries head..head+N-1, slot 0 oldest
//   rob_outputs_valid  min(occupancy, N)
//   num_retiring       head entries consumed by retire this cycle
//   restore_valid      mispredict squash request
//   restore_tail       index of the mispredicted branch (survives)
module rob_queue
  import rob_queue_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  ROB_PACKET [N-1:0]          rob_inputs,
  input  logic [NUM_SCALAR_BITS-1:0] rob_inputs_valid,
  output logic [NUM_SCALAR_BITS-1:0] rob_spots,
  output ROB_IDX                     rob_tail,
  output ROB_PACKET [N-1:0]          rob_outputs,
  output logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  logic [NUM_SCALAR_BITS-1:0] num_retiring,
  input  logic                       restore_valid,
  input  ROB_IDX                     restore_tail
);

  ROB_PACKET           buffer [ROB_SZ];
  ROB_IDX              head;
  ROB_IDX              tail;
  ROB_IDX              head_next;
  ROB_IDX              tail_next;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_next;

  // Pointer advance with an explicit modulo so non-power-of-two sizes wrap
  // correctly instead of relying on natural bit overflow.
  function automatic ROB_IDX mod_add(ROB_IDX base, int offset);
    int sum;
    sum = int'(base) + offset;
    return ROB_IDX'(sum % ROB_SZ);
  endfunction

  function automatic logic [NUM_SCALAR_BITS-1:0] min_n(int value);
    return (value < N) ? NUM_SCALAR_BITS'(value) : NUM_SCALAR_BITS'(N);
  endfunction

  // Retire always advances head. A restore rebuilds the occupancy from the
  // distance head->branch (the branch itself survives, hence +1) and drops
  // any dispatch arriving in the same cycle.
  always_comb begin
    head_next = mod_add(head, int'(num_retiring));
    if (restore_valid) begin
      tail_next  = mod_add(restore_tail, 1);
      count_next = CNT_BITS'(((int'(restore_tail) - int'(head) + ROB_SZ) % ROB_SZ)
                             + 1 - int'(num_retiring));
    end else begin
      tail_next  = mod_add(tail, int'(rob_inputs_valid));
      count_next = CNT_BITS'(int'(count) - int'(num_retiring) + int'(rob_inputs_valid));
    end
  end

  // Pointers and occupancy are cleared asynchronously so a mid-stream reset
  // empties the queue without waiting for an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Entry storage is left uninitialised; occupancy decides what is live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!restore_valid && (i < int'(rob_inputs_valid))) begin
        buffer[mod_add(tail, i)] <= rob_inputs[i];
      end
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rob_outputs[i] = buffer[mod_add(head, i)];
    end
  end

  assign rob_tail          = tail;
  assign rob_spots         = min_n(ROB_SZ - int'(count));
  assign rob_outputs_valid = min_n(int'(count));

endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed vector table, hand-written reset/restore corners and
// random traffic checked against a queue-based reference of the ROB.
module tb_rob_queue;
  import rob_queue_pkg::*;

  localparam int PKT_BITS = $bits(ROB_PACKET);

  logic                       clock;
  logic                       reset;
  ROB_PACKET [N-1:0]          rob_inputs;
  logic [NUM_SCALAR_BITS-1:0] rob_inputs_valid;
  logic [NUM_SCALAR_BITS-1:0] rob_spots;
  ROB_IDX                     rob_tail;
  ROB_PACKET [N-1:0]          rob_outputs;
  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid;
  logic [NUM_SCALAR_BITS-1:0] num_retiring;
  logic                       restore_valid;
  ROB_IDX                     restore_tail;

  rob_queue dut (
    .clock             (clock),
    .reset             (reset),
    .rob_inputs        (rob_inputs),
    .rob_inputs_valid  (rob_inputs_valid),
    .rob_spots         (rob_spots),
    .rob_tail          (rob_tail),
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .num_retiring      (num_retiring),
    .restore_valid     (restore_valid),
    .restore_tail      (restore_tail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference: program-order list of live packets plus head/tail indices.
  ROB_PACKET model_q[$];
  int        m_head = 0;
  int        m_tail = 0;
  ROB_PACKET cur_pkts [N];
  int        pkt_seq = 0;

  typedef struct {
    int disp;
    int ret;
    bit rst_v;
    int rt;
    int exp_valid;
    int exp_spots;
    int exp_tail;
    int exp_count;
    int exp_head;
  } vec_t;

  vec_t vecs[$];

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic cmp(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic makePackets(bit rnd);
    logic [PKT_BITS-1:0] raw;
    for (int i = 0; i < N; i++) begin
      if (rnd) raw = PKT_BITS'($urandom);
      else     raw = PKT_BITS'(pkt_seq * 37 + 5);
      pkt_seq++;
      cur_pkts[i] = raw;
    end
  endtask

  task automatic applyStimulus(int disp, int ret, bit rst_v, int rt, bit rnd);
    int keep;
    makePackets(rnd);
    for (int i = 0; i < N; i++) rob_inputs[i] = cur_pkts[i];
    rob_inputs_valid = NUM_SCALAR_BITS'(disp);
    num_retiring     = NUM_SCALAR_BITS'(ret);
    restore_valid    = rst_v;
    restore_tail     = ROB_IDX'(rt);
    @(posedge clock);
    #1;
    if (rst_v) begin
      keep = ((rt - m_head) % ROB_SZ + ROB_SZ) % ROB_SZ + 1;
      while (model_q.size() > keep) void'(model_q.pop_back());
      m_tail = (rt + 1) % ROB_SZ;
    end else begin
      for (int i = 0; i < disp; i++) model_q.push_back(cur_pkts[i]);
      m_tail = (m_tail + disp) % ROB_SZ;
    end
    for (int r = 0; r < ret; r++) void'(model_q.pop_front());
    m_head = (m_head + ret) % ROB_SZ;
    rob_inputs_valid = '0;
    num_retiring     = '0;
    restore_valid    = 1'b0;
  endtask

  task automatic checkOutput(string tag);
    int size;
    int vis;
    size = model_q.size();
    vis  = min_i(size, N);
    cmp({tag, " outputs_valid"}, int'(rob_outputs_valid), vis);
    cmp({tag, " spots"}, int'(rob_spots), min_i(ROB_SZ - size, N));
    cmp({tag, " tail"}, int'(rob_tail), m_tail);
    for (int i = 0; i < vis; i++) begin
      cmp($sformatf("%s slot%0d", tag, i), int'(rob_outputs[i]), int'(model_q[i]));
    end
  endtask

  initial begin
    reset            = 1'b0;
    rob_inputs       = '0;
    rob_inputs_valid = '0;
    num_retiring     = '0;
    restore_valid    = 1'b0;
    restore_tail     = '0;

    // Directed rows: fill to full, retire from full, wrap, restore.
    vecs.push_back('{3, 0, 0, 0, 3, 3, 3, 3, 0});
    vecs.push_back('{3, 0, 0, 0, 3, 2, 6, 6, 0});
    vecs.push_back('{2, 0, 0, 0, 3, 0, 0, 8, 0});
    vecs.push_back('{0, 3, 0, 0, 3, 3, 0, 5, 3});
    vecs.push_back('{3, 2, 0, 0, 3, 2, 3, 6, 5});
    vecs.push_back('{0, 1, 0, 0, 3, 3, 3, 5, 6});
    vecs.push_back('{3, 1, 1, 7, 1, 3, 0, 1, 7});
    vecs.push_back('{3, 0, 0, 0, 3, 3, 3, 4, 7});
    vecs.push_back('{1, 0, 0, 0, 3, 3, 4, 5, 7});

    // Held in reset across edges.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("in_reset");
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("reset_release");

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].disp, vecs[k].ret, vecs[k].rst_v, vecs[k].rt, 1'b0);
      cmp($sformatf("vec%0d outputs_valid", k), int'(rob_outputs_valid), vecs[k].exp_valid);
      cmp($sformatf("vec%0d spots", k), int'(rob_spots), vecs[k].exp_spots);
      cmp($sformatf("vec%0d tail", k), int'(rob_tail), vecs[k].exp_tail);
      cmp($sformatf("vec%0d count", k), int'(dut.count), vecs[k].exp_count);
      cmp($sformatf("vec%0d head", k), int'(dut.head), vecs[k].exp_head);
      checkOutput($sformatf("vec%0d", k));
    end

    // Asynchronous reset mid-stream with five live entries.
    #3;
    reset = 1'b0;
    #1;
    model_q.delete();
    m_head = 0;
    m_tail = 0;
    cmp("async_reset count", int'(dut.count), 0);
    checkOutput("async_reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1, 0, 1'b0, 0, 1'b0);
    checkOutput("post_reset_dispatch");

    // Restore onto head while that branch retires: queue ends empty.
    applyStimulus(0, 1, 1'b0, 0, 1'b0);
    applyStimulus(2, 0, 1'b0, 0, 1'b0);
    checkOutput("pre_restore_head");
    applyStimulus(0, 1, 1'b1, 1, 1'b0);
    cmp("restore_head count", int'(dut.count), 0);
    cmp("restore_head head", int'(dut.head), 2);
    cmp("restore_head tail", int'(rob_tail), 2);
    checkOutput("restore_head");
    applyStimulus(1, 0, 1'b0, 0, 1'b0);
    checkOutput("restore_head_refill");

    // Random legal traffic.
    for (int c = 0; c < 400; c++) begin
      int size;
      int spots;
      int vis;
      int disp;
      int ret;
      int off;
      int rt;
      bit rst_v;
      size  = model_q.size();
      spots = min_i(ROB_SZ - size, N);
      vis   = min_i(size, N);
      disp  = int'($urandom_range(0, spots));
      rst_v = (size > 0) && ($urandom_range(0, 7) == 0);
      rt    = 0;
      if (rst_v) begin
        off = int'($urandom_range(0, size - 1));
        rt  = (m_head + off) % ROB_SZ;
        ret = int'($urandom_range(0, min_i(vis, off + 1)));
      end else begin
        ret = int'($urandom_range(0, vis));
      end
      applyStimulus(disp, ret, rst_v, rt, 1'b1);
      checkOutput($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
